dma_request_scheduler: RTL and testbench
========================================

# dma_request_scheduler

Per-channel DMA request scheduler for the DMA controller. Samples unmasked `DREQ` lines, raises `HRQ` to the CPU, waits for `HLDA`, arbitrates between pending channels, and drives one-hot `DACK` for the winning channel until the service ends. It then releases the bus and returns to idle. It owns the `HRQ`/`HLDA`/`DACK` handshake used by timing-and-control and by the datapath.

## Interface
- `CHANNELS`, 4: number of DMA channels; must equal the package `CHANNELS`.
- `BURST_MAX`, 16: maximum grant cycles per service before release is forced; 0 means unlimited.
- `CLK` input 1: system clock; all state changes on the rising edge.
- `RESET` input 1: asynchronous, active-low reset.
- `DREQ` input `CHANNELS`: per-channel request, active-high, level-sensitive.
- `MASK` input `CHANNELS`: 1 masks the channel; masked requests are ignored.
- `HLDA` input 1: hold acknowledge from the CPU.
- `EOP_N` input 1: active-low end-of-process (terminal count or external).
- `HRQ` output 1: hold request to the CPU.
- `DACK` output `CHANNELS`: one-hot acknowledge; all-zero when no channel is granted.
- `ACTIVE_CH` output `$clog2(CHANNELS)`: index of the granted channel; valid only while `BUSY` is 1.
- `BUSY` output 1: 1 in the GRANT state.
- `DONE` output 1: one-cycle pulse in the first RELEASE cycle after a grant.

## Operation
- Effective request: `REQ = DREQ & ~MASK`.
- State IDLE:
  - `HRQ`=0, `DACK`=0.
  - If `REQ`≠0, go to WAIT_HLDA.
- State WAIT_HLDA:
  - `HRQ`=1.
  - When `HLDA`=1, arbitrate over the current `REQ`.
  - If a winner exists, latch it into `ACTIVE_CH`, clear the burst counter, and go to GRANT.
  - If `REQ`=0, go to RELEASE with no `DONE`.
- State GRANT:
  - `HRQ`=1, `DACK[ACTIVE_CH]`=1, `BUSY`=1.
  - The burst counter increments every cycle and saturates.
  - Exit to RELEASE when any of these holds: `DREQ[ACTIVE_CH]`=0; `MASK[ACTIVE_CH]`=1; `EOP_N`=0; the counter reaches `BURST_MAX`-1 (only when `BURST_MAX`≠0); `HLDA`=0 (bus preempted).
  - The grant never switches directly to another channel.
- State RELEASE:
  - `HRQ`=0, `DACK`=0.
  - `DONE`=1 in the first cycle if entered from GRANT.
  - Update the priority pointer.
  - When `HLDA`=0, go to IDLE; this can happen in the same cycle if `HLDA` is already low.
- Arbitration: fixed priority, channel 0 highest, unless the Configuration macro is enabled.
- Counter width: `$clog2(BURST_MAX+1)`, minimum 1 bit.

## Timing
- Reset values: all outputs 0, state IDLE, priority pointer 0, counter 0.
- `DREQ` asserted in cycle N (`HLDA` low) → `HRQ`=1 in cycle N+1.
- `HLDA` sampled high in cycle M → `DACK` one-hot in cycle M+1.
- Exit condition sampled in cycle K → `DACK`=0, `HRQ`=0, `DONE`=1 in cycle K+1.
- Under `BURST_MAX`=B, `DACK` stays high for exactly B cycles.
- Simultaneous `EOP_N`=0 and burst limit: a single release with a single `DONE`.
- A `DREQ` that rises while in RELEASE is served only after IDLE is re-entered; there is no back-to-back grant without `HLDA` cycling.
- Reset asserted mid-grant: outputs go to 0 asynchronously, the FSM goes to IDLE, and there is no `DONE` pulse.

## Configuration
- `DMA_ROTATING_PRIORITY_EN` defined:
  - The priority pointer becomes `(ACTIVE_CH+1) % CHANNELS` on every entry to RELEASE from GRANT, so the channel just served becomes lowest priority.
  - Arbitration searches upward from the pointer, with wrap-around.
- Not defined:
  - The pointer stays at 0, giving fixed priority with channel 0 highest.
  - The pointer logic is not synthesized.

## Test plan
- Basic handshake:
  - Stimulus: `DREQ`=4'b0100, `HLDA` raised 2 cycles after `HRQ`, `DREQ` held 5 cycles after `DACK`.
  - Required: `HRQ` 1 cycle after `DREQ`; `DACK`=4'b0100 and `ACTIVE_CH`=2 1 cycle after `HLDA`; release and one `DONE` pulse after `DREQ` drops.
- Priority:
  - Stimulus: `DREQ`=4'b1010 held through two services.
  - Required, fixed build: channel 1 is granted both times.
  - Required, `DMA_ROTATING_PRIORITY_EN` build: channel 1 first, then channel 3.
- Mask and empty arbitration:
  - Stimulus: `MASK`=4'b0001, `DREQ`=4'b0001.
  - Required: `HRQ` stays 0.
  - Stimulus: unmask, then drop `DREQ` before `HLDA`.
  - Required: RELEASE reached, no `DACK`, no `DONE`.
- Burst limit and EOP:
  - Stimulus: `BURST_MAX`=16, `DREQ` held.
  - Required: `DACK` high exactly 16 cycles.
  - Stimulus: pulse `EOP_N`=0 at grant cycle 3.
  - Required: `DACK` drops the next cycle.
- Preemption and reset:
  - Stimulus: drop `HLDA` mid-grant.
  - Required: `DACK`=0 and `HRQ`=0 the next cycle, then IDLE.
  - Stimulus: assert `RESET` low mid-grant.
  - Required: `HRQ`, `DACK`, `BUSY` go to 0 immediately; IDLE after reset.

Source files
------------

// File: rtl/dma_request_scheduler.sv
// DMA request scheduler: HRQ/HLDA handshake, arbitration, one-hot DACK.
// Optional DMA_ROTATING_PRIORITY_EN: rotating priority instead of fixed.
module dma_request_scheduler #(
  parameter int CHANNELS  = 4,
  parameter int BURST_MAX = 16
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [CHANNELS-1:0]         DREQ,
  input  logic [CHANNELS-1:0]         MASK,
  input  logic                        HLDA,
  input  logic                        EOP_N,
  output logic                        HRQ,
  output logic [CHANNELS-1:0]         DACK,
  output logic [$clog2(CHANNELS)-1:0] ACTIVE_CH,
  output logic                        BUSY,
  output logic                        DONE
);

  localparam int CH_W  = $clog2(CHANNELS);
  localparam int CNT_W = (BURST_MAX > 0) ? $clog2(BURST_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] LIM =
    CNT_W'((BURST_MAX > 0) ? BURST_MAX - 1 : 0);

  typedef enum logic [1:0] {
    IDLE, WAIT_HLDA, GRANT, RELEASE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CHANNELS-1:0] req;
  logic [CH_W-1:0]   act;
  logic [CH_W-1:0]   win;
  logic [CH_W-1:0]   ptr;
  logic              found;
  logic [CNT_W-1:0]  cnt;
  logic              limit_hit;
  logic              grant_exit;
  logic              from_grant;

  assign req       = DREQ & ~MASK;
  assign limit_hit = (BURST_MAX != 0) && (cnt == LIM);
  assign grant_exit = !DREQ[act] || MASK[act] || !EOP_N
                   || limit_hit || !HLDA;

  // Search upward from the pointer with wrap-around for the first request
  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      j = (int'(ptr) + i) % CHANNELS;
      if (!found && req[j]) begin
        found = 1'b1;
        win   = j[CH_W-1:0];
      end
    end
  end

`ifdef DMA_ROTATING_PRIORITY_EN
  // Served channel becomes lowest priority when its grant ends
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)
      ptr <= '0;
    else if (state == GRANT && grant_exit)
      ptr <= (act == CH_W'(CHANNELS - 1)) ? '0 : act + 1'b1;
  end
`else
  assign ptr = '0;
`endif

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (|req) state_nxt = WAIT_HLDA;
      WAIT_HLDA: begin
        if (!found)    state_nxt = RELEASE;
        else if (HLDA) state_nxt = GRANT;
      end
      GRANT:     if (grant_exit) state_nxt = RELEASE;
      RELEASE:   if (!HLDA) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Grant channel latch, burst counter and release-from-grant flag
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      act        <= '0;
      cnt        <= '0;
      from_grant <= 1'b0;
    end else begin
      from_grant <= (state == GRANT) && grant_exit;
      if (state == WAIT_HLDA && HLDA && found) begin
        act <= win;
        cnt <= '0;
      end else if (state == GRANT && cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Outputs decoded from state
  always_comb begin
    HRQ  = (state == WAIT_HLDA) || (state == GRANT);
    BUSY = (state == GRANT);
    DONE = (state == RELEASE) && from_grant;
    DACK = '0;
    if (state == GRANT) DACK[act] = 1'b1;
  end

  assign ACTIVE_CH = act;

endmodule

// File: tb/tb_dma_request_scheduler.sv
// Directed bench for dma_request_scheduler.
// Build with DMA_ROTATING_PRIORITY_EN to check the rotating variant.
module tb_dma_request_scheduler;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] DREQ;
  logic [3:0] MASK;
  logic       HLDA;
  logic       EOP_N;
  logic       HRQ;
  logic [3:0] DACK;
  logic [1:0] ACTIVE_CH;
  logic       BUSY;
  logic       DONE;

  int checks = 0;
  int errors = 0;

`ifdef DMA_ROTATING_PRIORITY_EN
  localparam logic [1:0] SECOND_CH = 2'd3;
`else
  localparam logic [1:0] SECOND_CH = 2'd1;
`endif

  dma_request_scheduler #(.CHANNELS(4), .BURST_MAX(16)) dut (
    .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .MASK(MASK),
    .HLDA(HLDA), .EOP_N(EOP_N), .HRQ(HRQ), .DACK(DACK),
    .ACTIVE_CH(ACTIVE_CH), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    DREQ = '0; MASK = '0; HLDA = 1'b0; EOP_N = 1'b1;
    tick();
    tick();
    RESET = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    DREQ = '0; MASK = '0; HLDA = 1'b0; EOP_N = 1'b1;
    #2;
    checks++;
    if ({HRQ, DACK, ACTIVE_CH, BUSY, DONE} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0",
               {HRQ, DACK, ACTIVE_CH, BUSY, DONE});
    end
    tick();
    RESET = 1'b1;
    tick();
    checks++;
    if (HRQ !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_hrq got %b want 0", HRQ);
    end
  endtask

  task automatic test_basic();
    DREQ = 4'b0100;
    tick();
    checks++;
    if (HRQ !== 1'b1 || DACK !== 4'b0) begin
      errors++;
      $display("FAIL basic_hrq got hrq=%b dack=%b want 1/0000", HRQ, DACK);
    end
    tick();
    tick();
    HLDA = 1'b1;
    tick();
    checks++;
    if (DACK !== 4'b0100 || ACTIVE_CH !== 2'd2 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL basic_grant got dack=%b ch=%0d busy=%b want 0100/2/1",
               DACK, ACTIVE_CH, BUSY);
    end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (DACK !== 4'b0100 || HRQ !== 1'b1) begin
      errors++;
      $display("FAIL basic_hold got dack=%b hrq=%b want 0100/1", DACK, HRQ);
    end
    DREQ = 4'b0000;
    tick();
    checks++;
    if (DACK !== 4'b0 || HRQ !== 1'b0 || DONE !== 1'b1) begin
      errors++;
      $display("FAIL basic_release got dack=%b hrq=%b done=%b want 0/0/1",
               DACK, HRQ, DONE);
    end
    tick();
    checks++;
    if (DONE !== 1'b0 || HRQ !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_once got done=%b hrq=%b want 0/0", DONE, HRQ);
    end
    HLDA = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_priority();
    do_reset();
    DREQ = 4'b1010;
    tick();
    HLDA = 1'b1;
    tick();
    checks++;
    if (ACTIVE_CH !== 2'd1 || DACK !== 4'b0010) begin
      errors++;
      $display("FAIL prio_first got ch=%0d dack=%b want 1/0010",
               ACTIVE_CH, DACK);
    end
    EOP_N = 1'b0;
    tick();
    EOP_N = 1'b1;
    HLDA = 1'b0;
    tick();
    tick();
    checks++;
    if (HRQ !== 1'b1) begin
      errors++;
      $display("FAIL prio_rerequest got hrq=%b want 1", HRQ);
    end
    HLDA = 1'b1;
    tick();
    checks++;
    if (ACTIVE_CH !== SECOND_CH || DACK !== (4'b0001 << SECOND_CH)) begin
      errors++;
      $display("FAIL prio_second got ch=%0d dack=%b want %0d",
               ACTIVE_CH, DACK, SECOND_CH);
    end
    DREQ = 4'b0000;
    HLDA = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_mask();
    MASK = 4'b0001;
    DREQ = 4'b0001;
    tick();
    tick();
    tick();
    checks++;
    if (HRQ !== 1'b0) begin
      errors++;
      $display("FAIL mask_hrq got %b want 0", HRQ);
    end
    MASK = 4'b0000;
    tick();
    checks++;
    if (HRQ !== 1'b1) begin
      errors++;
      $display("FAIL unmask_hrq got %b want 1", HRQ);
    end
    DREQ = 4'b0000;
    tick();
    checks++;
    if (HRQ !== 1'b0 || DACK !== 4'b0 || DONE !== 1'b0) begin
      errors++;
      $display("FAIL empty_arb got hrq=%b dack=%b done=%b want 0/0/0",
               HRQ, DACK, DONE);
    end
    tick();
    checks++;
    if (DONE !== 1'b0 || HRQ !== 1'b0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL empty_idle got done=%b hrq=%b busy=%b want 0/0/0",
               DONE, HRQ, BUSY);
    end
  endtask

  task automatic test_burst();
    int n;
    DREQ = 4'b0001;
    tick();
    HLDA = 1'b1;
    tick();
    n = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (DACK == 4'b0001) n++;
      else break;
    end
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL burst_len got %0d want 16", n);
    end
    checks++;
    if (DONE !== 1'b1) begin
      errors++;
      $display("FAIL burst_done got %b want 1", DONE);
    end
    DREQ = 4'b0000;
    HLDA = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_eop();
    DREQ = 4'b0001;
    tick();
    HLDA = 1'b1;
    tick();
    tick();
    tick();
    EOP_N = 1'b0;
    tick();
    EOP_N = 1'b1;
    checks++;
    if (DACK !== 4'b0 || DONE !== 1'b1 || HRQ !== 1'b0) begin
      errors++;
      $display("FAIL eop_release got dack=%b done=%b hrq=%b want 0/1/0",
               DACK, DONE, HRQ);
    end
    DREQ = 4'b0000;
    HLDA = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_eop_at_limit();
    DREQ = 4'b0001;
    tick();
    HLDA = 1'b1;
    tick();
    for (int i = 0; i < 15; i++) tick();
    EOP_N = 1'b0;
    tick();
    EOP_N = 1'b1;
    checks++;
    if (DONE !== 1'b1 || DACK !== 4'b0) begin
      errors++;
      $display("FAIL eop_limit_done got done=%b dack=%b want 1/0",
               DONE, DACK);
    end
    tick();
    tick();
    checks++;
    if (DONE !== 1'b0 || DACK !== 4'b0 || HRQ !== 1'b0) begin
      errors++;
      $display("FAIL no_back_to_back got done=%b dack=%b hrq=%b want 0/0/0",
               DONE, DACK, HRQ);
    end
    HLDA = 1'b0;
    tick();
    tick();
    checks++;
    if (HRQ !== 1'b1) begin
      errors++;
      $display("FAIL rerequest_after_idle got hrq=%b want 1", HRQ);
    end
    DREQ = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_preempt();
    DREQ = 4'b0100;
    tick();
    HLDA = 1'b1;
    tick();
    tick();
    HLDA = 1'b0;
    tick();
    checks++;
    if (DACK !== 4'b0 || HRQ !== 1'b0 || DONE !== 1'b1) begin
      errors++;
      $display("FAIL preempt got dack=%b hrq=%b done=%b want 0/0/1",
               DACK, HRQ, DONE);
    end
    DREQ = 4'b0000;
    tick();
    tick();
    checks++;
    if (HRQ !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
      errors++;
      $display("FAIL preempt_idle got hrq=%b busy=%b done=%b want 0/0/0",
               HRQ, BUSY, DONE);
    end
  endtask

  task automatic test_reset_mid();
    DREQ = 4'b0010;
    tick();
    HLDA = 1'b1;
    tick();
    tick();
    checks++;
    if (BUSY !== 1'b1 || DACK !== 4'b0010) begin
      errors++;
      $display("FAIL rst_pre_grant got busy=%b dack=%b want 1/0010",
               BUSY, DACK);
    end
    RESET = 1'b0;
    #1;
    checks++;
    if (HRQ !== 1'b0 || DACK !== 4'b0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
      errors++;
      $display("FAIL rst_async got hrq=%b dack=%b busy=%b done=%b want 0",
               HRQ, DACK, BUSY, DONE);
    end
    DREQ = 4'b0000;
    HLDA = 1'b0;
    tick();
    RESET = 1'b1;
    tick();
    checks++;
    if (HRQ !== 1'b0 || DONE !== 1'b0 || ACTIVE_CH !== 2'd0) begin
      errors++;
      $display("FAIL rst_idle got hrq=%b done=%b ch=%0d want 0/0/0",
               HRQ, DONE, ACTIVE_CH);
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_basic();
    test_mask();
    test_burst();
    test_eop();
    test_eop_at_limit();
    test_preempt();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
